// File: rtl/cls_seq_pkg.sv
// Shared FSM state type and datapath widths for the classifier sequencer.
package cls_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_FLUSH,
      ST_WAIT
   } state_t;

   localparam int X_W            = 4;
   localparam int W_W            = 8;
   localparam int ACC_W          = 20;
   localparam int DEF_FLUSH_WAIT = 2;

endpackage

// File: rtl/cls_seq_pipe.sv
// Two-stage operand pipeline: a tag stage aligned with memory read data,
// then an output stage that presents operands and strobes to the MAC.
module cls_seq_pipe
   import cls_seq_pkg::*;
#(
   parameter int CLASS_BITS = 3
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         issue,
   input  logic                         issue_first,
   input  logic        [CLASS_BITS-1:0] issue_class,
   input  logic signed [X_W-1:0]        x_data,
   input  logic signed [W_W-1:0]        w_data,
   output logic signed [X_W-1:0]        mac_x,
   output logic signed [W_W-1:0]        mac_w,
   output logic                         mac_new_feat,
   output logic                         mac_new_class,
   output logic        [CLASS_BITS-1:0] mac_class_id,
   output logic                         empty
);

   logic                  tag_valid;
   logic                  tag_first;
   logic [CLASS_BITS-1:0] tag_class;

   // NOTE: non-blocking assignments here so each stage captures the value its
   // predecessor held before the edge; blocking would collapse the two stages.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tag_valid     <= 1'b0;
         tag_first     <= 1'b0;
         tag_class     <= '0;
         mac_x         <= '0;
         mac_w         <= '0;
         mac_new_feat  <= 1'b0;
         mac_new_class <= 1'b0;
         mac_class_id  <= '0;
      end else begin
         tag_valid     <= issue;
         tag_first     <= issue_first;
         tag_class     <= issue_class;
         mac_new_feat  <= tag_valid;
         mac_new_class <= tag_valid & tag_first;
         if (tag_valid) begin
            mac_x        <= x_data;
            mac_w        <= w_data;
            mac_class_id <= tag_class;
         end
      end
   end

   // Tag stage idle: whatever sits in the output stage leaves on this edge.
   assign empty = ~tag_valid;

endmodule

// File: rtl/classifier_seq_ctrl.sv
// Sequencer streaming feature/weight pairs into the classifier MAC/argmax.
// Optional issue stall via `hold` when CLS_SEQ_HOLD_EN is defined.
module classifier_seq_ctrl
   import cls_seq_pkg::*;
#(
   parameter int NUM_FEAT   = 16,
   parameter int NUM_CLASS  = 8,
   parameter int CLASS_BITS = 3,
   parameter int FLUSH_WAIT = DEF_FLUSH_WAIT,
   parameter int FA_W       = $clog2(NUM_FEAT),
   parameter int WA_W       = $clog2(NUM_FEAT * NUM_CLASS)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   output logic                         busy,
   output logic                         done,
   output logic                         feat_re,
   output logic        [FA_W-1:0]       feat_addr,
   input  logic signed [X_W-1:0]        feat_rdata,
   output logic                         w_re,
   output logic        [WA_W-1:0]       w_addr,
   input  logic signed [W_W-1:0]        w_rdata,
   output logic signed [X_W-1:0]        mac_x,
   output logic signed [W_W-1:0]        mac_w,
   output logic                         mac_new_feat,
   output logic                         mac_new_class,
   output logic        [CLASS_BITS-1:0] mac_class_id,
   output logic                         mac_flush,
   input  logic signed [ACC_W-1:0]      mac_max_score,
   input  logic        [CLASS_BITS-1:0] mac_max_class,
   output logic signed [ACC_W-1:0]      result_score,
   output logic        [CLASS_BITS-1:0] result_class,
   input  logic                         hold
);

   localparam int WC_W = (FLUSH_WAIT > 1) ? $clog2(FLUSH_WAIT + 1) : 1;

   state_t                state;
   logic                  issue_q;
   logic [CLASS_BITS-1:0] c_idx;
   logic [WC_W-1:0]       wait_cnt;
   logic                  stall;
   logic                  issue;
   logic                  last_pair;
   logic                  pipe_empty;
   logic                  finish;

`ifdef CLS_SEQ_HOLD_EN
   assign stall = hold & issue_q;
`else
   logic unused_hold;
   assign unused_hold = hold;
   assign stall       = 1'b0;
`endif

   assign issue     = issue_q & ~stall;
   assign feat_re   = issue;
   assign w_re      = issue;
   assign last_pair = (feat_addr == FA_W'(NUM_FEAT - 1)) &&
                      (c_idx == CLASS_BITS'(NUM_CLASS - 1));

   // NOTE: default first so every path assigns and no latch is inferred.
   always_comb begin
      finish = 1'b0;
      if (state == ST_FLUSH)
         finish = (FLUSH_WAIT == 1);
      else if (state == ST_WAIT)
         finish = (wait_cnt == WC_W'(1));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         issue_q      <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         mac_flush    <= 1'b0;
         feat_addr    <= '0;
         w_addr       <= '0;
         c_idx        <= '0;
         wait_cnt     <= '0;
         result_score <= '0;
         result_class <= '0;
      end else begin
         done      <= 1'b0;
         mac_flush <= 1'b0;
         case (state)
            ST_IDLE: if (start) begin
               state     <= ST_RUN;
               busy      <= 1'b1;
               issue_q   <= 1'b1;
               feat_addr <= '0;
               w_addr    <= '0;
               c_idx     <= '0;
            end
            ST_RUN: if (issue) begin
               if (last_pair) begin
                  state   <= ST_DRAIN;
                  issue_q <= 1'b0;
               end else begin
                  w_addr <= w_addr + 1'b1;
                  if (feat_addr == FA_W'(NUM_FEAT - 1)) begin
                     feat_addr <= '0;
                     c_idx     <= c_idx + 1'b1;
                  end else begin
                     feat_addr <= feat_addr + 1'b1;
                  end
               end
            end
            ST_DRAIN: if (pipe_empty) begin
               state     <= ST_FLUSH;
               mac_flush <= 1'b1;
            end
            ST_FLUSH: begin
               state    <= ST_WAIT;
               wait_cnt <= WC_W'(FLUSH_WAIT - 1);
            end
            ST_WAIT: begin
               // The final WAIT cycle is the done cycle; leave IDLE only after it.
               if (wait_cnt == '0) state <= ST_IDLE;
               else                wait_cnt <= wait_cnt - 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
         if (finish) begin
            done         <= 1'b1;
            busy         <= 1'b0;
            result_score <= mac_max_score;
            result_class <= mac_max_class;
         end
      end
   end

   cls_seq_pipe #(
      .CLASS_BITS(CLASS_BITS)
   ) u_pipe (
      .clk          (clk),
      .rst_n        (rst_n),
      .issue        (issue),
      .issue_first  (feat_addr == '0),
      .issue_class  (c_idx),
      .x_data       (feat_rdata),
      .w_data       (w_rdata),
      .mac_x        (mac_x),
      .mac_w        (mac_w),
      .mac_new_feat (mac_new_feat),
      .mac_new_class(mac_new_class),
      .mac_class_id (mac_class_id),
      .empty        (pipe_empty)
   );

endmodule

// File: tb/tb_classifier_seq_ctrl.sv
// Directed bench for classifier_seq_ctrl: default instance plus a 2x2 instance.
module tb_classifier_seq_ctrl;
   import cls_seq_pkg::*;

`ifdef CLS_SEQ_HOLD_EN
   localparam int HOLD_DONE = 138;
`else
   localparam int HOLD_DONE = 133;
`endif

   logic clk = 1'b0;
   logic rst_n, start, hold;
   logic busy, done, feat_re, w_re, mac_new_feat, mac_new_class, mac_flush;
   logic [3:0] feat_addr;
   logic [6:0] w_addr;
   logic signed [3:0] feat_rdata, mac_x;
   logic signed [7:0] w_rdata, mac_w;
   logic [2:0] mac_class_id, mac_max_class, result_class;
   logic signed [19:0] mac_max_score, result_score;

   logic s_start, s_busy, s_done, s_feat_re, s_w_re, s_new_feat, s_new_class, s_flush;
   logic s_feat_addr, s_class_id, s_res_class;
   logic [1:0] s_w_addr;
   logic signed [3:0] s_feat_rdata, s_mac_x;
   logic signed [7:0] s_w_rdata, s_mac_w;
   logic signed [19:0] s_res_score;

   always #5 clk = ~clk;

   classifier_seq_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .feat_re(feat_re), .feat_addr(feat_addr), .feat_rdata(feat_rdata),
      .w_re(w_re), .w_addr(w_addr), .w_rdata(w_rdata),
      .mac_x(mac_x), .mac_w(mac_w), .mac_new_feat(mac_new_feat),
      .mac_new_class(mac_new_class), .mac_class_id(mac_class_id), .mac_flush(mac_flush),
      .mac_max_score(mac_max_score), .mac_max_class(mac_max_class),
      .result_score(result_score), .result_class(result_class), .hold(hold)
   );

   classifier_seq_ctrl #(.NUM_FEAT(2), .NUM_CLASS(2), .CLASS_BITS(1), .FLUSH_WAIT(1)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(s_start), .busy(s_busy), .done(s_done),
      .feat_re(s_feat_re), .feat_addr(s_feat_addr), .feat_rdata(s_feat_rdata),
      .w_re(s_w_re), .w_addr(s_w_addr), .w_rdata(s_w_rdata),
      .mac_x(s_mac_x), .mac_w(s_mac_w), .mac_new_feat(s_new_feat),
      .mac_new_class(s_new_class), .mac_class_id(s_class_id), .mac_flush(s_flush),
      .mac_max_score(-20'sd5), .mac_max_class(1'b1),
      .result_score(s_res_score), .result_class(s_res_class), .hold(1'b0)
   );

   // Memory models with one-cycle read latency.
   logic signed [3:0] fmem [16];
   logic signed [7:0] wmem [128];
   always @(posedge clk) begin
      if (feat_re) feat_rdata <= fmem[feat_addr];
      if (w_re)    w_rdata    <= wmem[w_addr];
      if (s_feat_re) s_feat_rdata <= s_feat_addr ? 4'sd2 : 4'sd1;
      if (s_w_re)    s_w_rdata    <= $signed({6'b0, s_w_addr}) - 8'sd3;
   end

   // Reference MAC/argmax: per-class accumulate, argmax (lowest index on tie) at flush.
   logic signed [19:0] acc [8];
   logic signed [19:0] best;
   int bi;
   always @(posedge clk) begin
      if (!rst_n) begin
         mac_max_score <= '0;
         mac_max_class <= '0;
      end else begin
         if (mac_new_feat) begin
            if (mac_new_class) acc[mac_class_id] <= mac_x * mac_w;
            else               acc[mac_class_id] <= acc[mac_class_id] + mac_x * mac_w;
         end
         if (mac_flush) begin
            best = acc[0];
            bi = 0;
            for (int c = 1; c < 8; c++) if (acc[c] > best) begin best = acc[c]; bi = c; end
            mac_max_score <= best;
            mac_max_class <= 3'(bi);
         end
      end
   end

   int n_checks = 0, n_fail = 0;

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Captured run trace.
   int n_str, n_wa, n_fa, flush_t, flush_n, done_t, done_n, nc_bad;
   logic signed [3:0] s_x [256], r_x [256];
   logic signed [7:0] s_w [256], r_w [256];
   logic [2:0] s_cls [256], r_cls [256];
   logic s_new [256], r_new [256];
   int s_t [256], wa_seq [256], fa_seq [256];
   logic busy_h [512], re_h [512];
   logic signed [19:0] res_s;
   logic [2:0] res_c;

   task automatic run(input int hold_lo, input int hold_hi, input bit start_hold,
                      input int pulse_t, input int rst_t);
      n_str = 0; n_wa = 0; n_fa = 0; flush_n = 0; done_n = 0; nc_bad = 0;
      flush_t = -1; done_t = -1;
      @(negedge clk); start = 1'b1;
      @(posedge clk);
      for (int t = 1; t < 400; t++) begin
         @(negedge clk);
         start = start_hold || (t == pulse_t);
         hold  = (t >= hold_lo) && (t <= hold_hi);
         #1;
         busy_h[t] = busy;
         re_h[t]   = feat_re;
         if (feat_re && n_fa < 256) begin fa_seq[n_fa] = feat_addr; n_fa++; end
         if (w_re && n_wa < 256) begin wa_seq[n_wa] = w_addr; n_wa++; end
         if (mac_new_feat && n_str < 256) begin
            s_x[n_str] = mac_x; s_w[n_str] = mac_w; s_cls[n_str] = mac_class_id;
            s_new[n_str] = mac_new_class; s_t[n_str] = t; n_str++;
         end
         if (mac_new_class && !mac_new_feat) nc_bad++;
         if (mac_flush) begin flush_n++; if (flush_t < 0) flush_t = t; end
         if (done) begin
            done_n++;
            if (done_t < 0) begin done_t = t; res_s = result_score; res_c = result_class; end
         end
         if (t == rst_t) rst_n = 1'b0;
         if (t == rst_t + 1) break;
         if (done_t > 0 && t >= done_t + 2) break;
      end
      start = 1'b0;
      hold  = 1'b0;
   endtask

   task automatic check_zero(input string p);
      check({p, "_busy"}, busy, 0);          check({p, "_done"}, done, 0);
      check({p, "_feat_re"}, feat_re, 0);    check({p, "_w_re"}, w_re, 0);
      check({p, "_feat_addr"}, feat_addr, 0); check({p, "_w_addr"}, w_addr, 0);
      check({p, "_mac_x"}, mac_x, 0);        check({p, "_mac_w"}, mac_w, 0);
      check({p, "_new_feat"}, mac_new_feat, 0); check({p, "_new_class"}, mac_new_class, 0);
      check({p, "_class_id"}, mac_class_id, 0); check({p, "_flush"}, mac_flush, 0);
      check({p, "_res_score"}, result_score, 0); check({p, "_res_class"}, result_class, 0);
   endtask

   task automatic check_busy(input string p);
      int bad = 0;
      for (int t = 1; t < done_t; t++) if (busy_h[t] !== 1'b1) bad++;
      check({p, "_busy_run"}, bad, 0);
      check({p, "_busy_done"}, busy_h[done_t], 0);
   endtask

   int bad, cnt, sn, s_flush_t, s_done_t;
   int st [8];
   logic signed [3:0] sx [8];
   logic signed [7:0] sw [8];
   logic snew [8], scls [8];
   logic signed [19:0] s_rs;
   logic s_rc;
   int sx_e [4] = '{1, 2, 1, 2};
   int sw_e [4] = '{-3, -2, -1, 0};

   initial begin
      rst_n = 1'b0; start = 1'b0; hold = 1'b0; s_start = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_zero("por");
      rst_n = 1'b1;

      // Pattern A: feat=1, w=class+1; class 7 wins with 16*8.
      for (int i = 0; i < 16; i++) fmem[i] = 4'sd1;
      for (int a = 0; a < 128; a++) wmem[a] = 8'(a / 16 + 1);
      run(-1, -1, 1'b0, -1, -10);
      check("a_strobes", n_str, 128);
      check("a_first_strobe", s_t[0], 3);
      check("a_last_strobe", s_t[127], 130);
      check("a_flush_t", flush_t, 131);
      check("a_flush_n", flush_n, 1);
      check("a_done_t", done_t, 133);
      check("a_done_n", done_n, 1);
      check("a_res_class", res_c, 7);
      check("a_res_score", res_s, 128);
      check("a_newclass_alone", nc_bad, 0);
      cnt = 0;
      for (int k = 0; k < n_str; k++) if (s_new[k]) cnt++;
      check("a_newclass_count", cnt, 8);
      for (int c = 0; c < 8; c++) begin
         check($sformatf("a_nc%0d_flag", c), s_new[16 * c], 1);
         check($sformatf("a_nc%0d_t", c), s_t[16 * c], 3 + 16 * c);
         check($sformatf("a_nc%0d_id", c), s_cls[16 * c], c);
      end
      check("a_waddr_n", n_wa, 128);
      check("a_faddr_n", n_fa, 128);
      bad = 0;
      for (int k = 0; k < 128; k++) if (wa_seq[k] != k || fa_seq[k] != k % 16) bad++;
      check("a_addr_sweep", bad, 0);
      check_busy("a");
      check("a_idle_re", feat_re, 0);
      check("a_idle_waddr_hold", w_addr, 127);

      // Pattern B: signed data; score(c) = 792 - 128c, class 0 wins.
      for (int i = 0; i < 16; i++) fmem[i] = 4'(i - 8);
      for (int a = 0; a < 128; a++) wmem[a] = 8'(a - 64);
      run(-1, -1, 1'b0, -1, -10);
      check("b_strobes", n_str, 128);
      bad = 0;
      for (int k = 0; k < n_str; k++)
         if (s_x[k] !== fmem[k % 16] || s_w[k] !== wmem[k] || s_cls[k] !== 3'(k / 16) ||
             s_new[k] !== (k % 16 == 0)) bad++;
      check("b_stream", bad, 0);
      check("b_done_t", done_t, 133);
      check("b_res_class", res_c, 0);
      check("b_res_score", res_s, 792);
      for (int k = 0; k < 128; k++) begin
         r_x[k] = s_x[k]; r_w[k] = s_w[k]; r_cls[k] = s_cls[k]; r_new[k] = s_new[k];
      end

      // Hold asserted cycles 10..14.
      run(10, 14, 1'b0, -1, -10);
      check("h_strobes", n_str, 128);
      bad = 0;
      for (int k = 0; k < 128; k++)
         if (s_x[k] !== r_x[k] || s_w[k] !== r_w[k] || s_cls[k] !== r_cls[k] ||
             s_new[k] !== r_new[k]) bad++;
      check("h_stream", bad, 0);
      check("h_done_t", done_t, HOLD_DONE);
      check("h_res_score", res_s, 792);
      cnt = 0;
      for (int t = 10; t <= 14; t++) if (re_h[t]) cnt++;
`ifdef CLS_SEQ_HOLD_EN
      check("h_re_held", cnt, 0);
`else
      check("h_re_held", cnt, 5);
`endif
      check_busy("h");

      // start held high plus a pulse at 50: one done, restart only from IDLE.
      run(-1, -1, 1'b1, 50, -10);
      check("s_done_n", done_n, 1);
      check("s_done_t", done_t, 133);
      check("s_busy_after_done", busy_h[done_t + 1], 0);
      check("s_busy_restart", busy_h[done_t + 2], 1);
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;

      // Reset mid-inference at cycle 40, then a fresh run.
      run(-1, -1, 1'b0, -1, 40);
      check_zero("mrst");
      rst_n = 1'b1;
      run(-1, -1, 1'b0, -1, -10);
      check("r_done_t", done_t, 133);
      check("r_strobes", n_str, 128);
      check("r_res_score", res_s, 792);

      // Small instance: 2 features x 2 classes, FLUSH_WAIT=1.
      sn = 0; s_flush_t = -1; s_done_t = -1;
      @(negedge clk); s_start = 1'b1;
      @(posedge clk);
      for (int t = 1; t <= 20; t++) begin
         @(negedge clk);
         s_start = 1'b0;
         #1;
         if (s_new_feat && sn < 8) begin
            st[sn] = t; sx[sn] = s_mac_x; sw[sn] = s_mac_w;
            snew[sn] = s_new_class; scls[sn] = s_class_id; sn++;
         end
         if (s_flush && s_flush_t < 0) s_flush_t = t;
         if (s_done && s_done_t < 0) begin s_done_t = t; s_rs = s_res_score; s_rc = s_res_class; end
         if (s_done_t > 0) break;
      end
      check("sm_strobes", sn, 4);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("sm%0d_t", k), st[k], 3 + k);
         check($sformatf("sm%0d_x", k), sx[k], sx_e[k]);
         check($sformatf("sm%0d_w", k), sw[k], sw_e[k]);
         check($sformatf("sm%0d_new", k), snew[k], (k % 2 == 0));
         check($sformatf("sm%0d_id", k), scls[k], k / 2);
      end
      check("sm_flush_t", s_flush_t, 7);
      check("sm_done_t", s_done_t, 8);
      check("sm_res_score", s_rs, -5);
      check("sm_res_class", s_rc, 1);
      check("sm_busy_done", s_busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/classifier_seq_ctrl.md
# classifier_seq_ctrl

Sequencer for the INT4×INT8 classifier MAC/argmax datapath. On a `start` pulse it streams every feature/weight pair for every class out of external synchronous memories into the MAC. It marks class boundaries, flushes the argmax stage and latches the winning class and score. It sits between the feature buffer and weight ROM on one side and the `classifier_top` datapath on the other.

## Interface
Parameters:
- `NUM_FEAT`, 16: features per class (≥2).
- `NUM_CLASS`, 8: number of classes (≥2, ≤ 2^CLASS_BITS).
- `CLASS_BITS`, 3: class id width.
- `FLUSH_WAIT`, 2: cycles from `mac_flush` until MAC max outputs are valid.
- `FA_W`, $clog2(NUM_FEAT): feature address width.
- `WA_W`, $clog2(NUM_FEAT*NUM_CLASS): weight address width.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: begin one inference; sampled only in IDLE.
- `busy` out 1: inference in progress.
- `done` out 1: one-cycle pulse; result valid.
- `feat_re` out 1: feature buffer read enable.
- `feat_addr` out FA_W: feature index.
- `feat_rdata` in 4 (signed): feature data, 1-cycle read latency.
- `w_re` out 1: weight ROM read enable.
- `w_addr` out WA_W: class*NUM_FEAT + feature.
- `w_rdata` in 8 (signed): weight data, 1-cycle read latency.
- `mac_x` out 4 (signed), `mac_w` out 8 (signed): operands to MAC.
- `mac_new_feat` out 1: operand pair valid this cycle.
- `mac_new_class` out 1: pair is first of class `mac_class_id`.
- `mac_class_id` out CLASS_BITS: class of current pair.
- `mac_flush` out 1: one-cycle pulse; commit last class to argmax.
- `mac_max_score` in 20 (signed), `mac_max_class` in CLASS_BITS: MAC argmax outputs.
- `result_score` out 20 (signed), `result_class` out CLASS_BITS: latched result.
- `hold` in 1: issue stall (only with `CLS_SEQ_HOLD_EN`).

## Operation
- FSM: IDLE → RUN → DRAIN → FLUSH → WAIT → IDLE.
- IDLE: `start`=1 → RUN; counters `f_idx`=0, `c_idx`=0.
- RUN: each non-stalled cycle asserts `feat_re`=`w_re`=1, `feat_addr`=f_idx, `w_addr`=c_idx*NUM_FEAT+f_idx. Then f_idx increments. On wrap (NUM_FEAT-1→0), c_idx increments. Issue of (NUM_CLASS-1, NUM_FEAT-1) → DRAIN.
- A tag register (valid, first=(f_idx==0), class=c_idx) tracks each issue; it aligns with rdata one cycle later.
- Output stage registers `mac_x`/`mac_w` from rdata, plus the tag strobes, one cycle after rdata.
- DRAIN: stays until tag and output stages are empty → FLUSH.
- FLUSH: `mac_flush`=1 for one cycle → WAIT.
- WAIT: FLUSH_WAIT cycles; on the last cycle, latch `result_*` from `mac_max_*`, pulse `done`, → IDLE.
- `start` while not IDLE is ignored. `start` in the same cycle as `done` is ignored; it must be re-presented in IDLE.
- `feat_re`/`w_re` are low outside RUN. Addresses hold their last value when not enabled.
- Reset, including mid-inference, returns to IDLE. Reset values:
  - `busy`, `done`, `feat_re`, `w_re`, `mac_new_feat`, `mac_new_class`, `mac_flush`, `hold` effect = 0.
  - All addresses, `mac_x`, `mac_w`, `mac_class_id`, `result_score`, `result_class` = 0.
  - In-flight tags are discarded.

## Timing
- `start` accepted at cycle 0. RUN issues at cycles 1..N, where N = NUM_FEAT*NUM_CLASS.
- Pair k (issued at cycle k) appears on `mac_*` at cycle k+2.
- Last strobe at N+2; `mac_flush` at N+3; `done` at N+3+FLUSH_WAIT.
- `busy`=1 from cycle 1 through the cycle before `done`, and 0 in the `done` cycle.
- Defaults: N=128; last strobe at 130, flush at 131, done at 133.
- `mac_new_class`=1 only together with `mac_new_feat`=1.

## Configuration
- `CLS_SEQ_HOLD_EN` defined:
  - `hold`=1 in RUN suppresses issue that cycle (`*_re`=0, counters frozen).
  - Pairs already issued continue through the pipe and are still presented.
  - The stream content is unchanged; completion is delayed by the number of held cycles.
  - `hold` is ignored outside RUN.
- `CLS_SEQ_HOLD_EN` undefined: the `hold` port exists but is ignored; timing is exactly as above.

## Structure
- Shared package `cls_seq_pkg`:
  - FSM state enum.
  - Operand widths (4, 8), accumulator width (20).
  - Default `FLUSH_WAIT`.
- One sub-module, `cls_seq_pipe`: two-stage operand/tag pipeline (tag stage + output stage) with an empty flag. The FSM and counters stay in the top.

## Test plan
- Default params, feat[i]=1, w[c*16+i]=c+1:
  - 128 strobes; `mac_new_class` at cycles 3,19,…,115 with class_id 0..7.
  - `mac_flush` at 131; `done` at 133.
  - Result class 7, score 128 (from a reference MAC model).
- Address sweep: record all `w_addr` values → exactly 0..127 in order; `feat_addr` cycles 0..15 eight times.
- `start` held high through the run, plus a pulse at cycle 50 → exactly one `done`; a second run begins only once `start` is seen in IDLE.
- Reset asserted at cycle 40 → next cycle all outputs are 0 and the FSM is IDLE; a fresh `start` gives `done` 133 cycles later.
- With `CLS_SEQ_HOLD_EN`, `hold`=1 for cycles 10–14 → the strobe sequence matches the unstalled run value-for-value; `done` at cycle 138.
- NUM_FEAT=2, NUM_CLASS=2, FLUSH_WAIT=1 → strobes at cycles 3–6, flush at 7, `done` at 8.
